// File: rtl/galpal_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : galpal_pkg                                                        |
// | Brief   : Shared 16R8 PAL geometry, checksum width and loader state codes.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package galpal_pkg;

   localparam int GAL16R8_ROWS = 64;
   localparam int GAL16R8_COLS = 32;
   localparam int CSUM_W       = 16;

   localparam int c_ST_W = 3;
   typedef logic [c_ST_W-1:0] state_t;

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_LOAD  = 3'd1;
   localparam logic [2:0] c_ST_WRITE = 3'd2;
   localparam logic [2:0] c_ST_CHECK = 3'd3;
   localparam logic [2:0] c_ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/galpal_fuse_loader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : galpal_fuse_loader_if                                             |
// | Brief   : Fuse byte stream plus row-write port of the PAL fuse loader.      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface galpal_fuse_loader_if #(
   parameter int ROWS = 64,
   parameter int COLS = 32
);
   localparam int RW = $clog2(ROWS);

   logic [7:0]      s_data;
   logic            s_valid;
   logic            s_ready;
   logic            wr_en;
   logic [RW-1:0]   wr_row;
   logic [COLS-1:0] wr_data;

   // master: host/ROM side that sources bytes and observes row writes
   modport master (output s_data, s_valid, input s_ready, wr_en, wr_row, wr_data);
   modport slave  (input s_data, s_valid, output s_ready, wr_en, wr_row, wr_data);

endinterface
`default_nettype wire

// File: rtl/galpal_csum16.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : galpal_csum16                                                     |
// | Brief   : Byte accumulator mod 2^CSUM_W with synchronous clear.             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module galpal_csum16
   import galpal_pkg::*;
(
   input  wire                clk,
   input  wire                rst,
   input  wire                i_clr,
   input  wire                i_add_en,
   input  wire  [7:0]         i_data,
   output logic [CSUM_W-1:0]  o_sum
);

   logic [CSUM_W-1:0] r_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum <= '0;
      end else if (i_clr) begin
         r_sum <= '0;
      end else if (i_add_en) begin
         r_sum <= r_sum + {{(CSUM_W-8){1'b0}}, i_data};
      end
   end

   assign o_sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/galpal_fuse_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : galpal_fuse_loader                                                |
// | Brief   : Packs a JEDEC fuse byte stream into PAL rows, checksums it and    |
// |           gates the PAL output enable until a clean map is loaded.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module galpal_fuse_loader
   import galpal_pkg::*;
#(
   parameter int ROWS = GAL16R8_ROWS,
   parameter int COLS = GAL16R8_COLS
)(
   input  wire                       clk,
   input  wire                       rst,
   input  wire                       start,
   input  wire                       abort,
   galpal_fuse_loader_if.slave       bus,
   input  wire  [CSUM_W-1:0]         exp_csum,
   output logic                      pal_oe_n,
   output logic                      busy,
   output logic                      done,
   output logic [CSUM_W-1:0]         csum,
   output logic                      csum_err
);

   localparam int RW  = $clog2(ROWS);
   localparam int BPR = COLS / 8;
   localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
   localparam logic [BW-1:0] c_LAST_BYTE = BW'(BPR - 1);
   localparam logic [RW-1:0] c_LAST_ROW  = RW'(ROWS - 1);

   state_t          r_state;
   state_t          w_next;
   logic [RW-1:0]   r_row;
   logic [BW-1:0]   r_byte;
   logic            r_s_ready;
   logic            r_wr_en;
   logic [RW-1:0]   r_wr_row;
   logic [COLS-1:0] r_wr_data;
   logic            r_pal_oe_n;
   logic            r_busy;
   logic            r_done;
   logic            r_csum_err;
   logic            w_err_next;

   // s_ready is only ever high in LOAD, so it doubles as the state qualifier
   wire w_accept    = bus.s_valid && r_s_ready && !abort;
   wire w_start     = start && !abort && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
   wire w_last_byte = (r_byte == c_LAST_BYTE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE,
         c_ST_DONE:  if (start) w_next = c_ST_LOAD;
         c_ST_LOAD:  if (w_accept && w_last_byte) w_next = c_ST_WRITE;
         c_ST_WRITE: w_next = (r_row == c_LAST_ROW) ? c_ST_CHECK : c_ST_LOAD;
         c_ST_CHECK: w_next = c_ST_DONE;
         default:    w_next = c_ST_IDLE;
      endcase
      if (abort) w_next = c_ST_IDLE;
   end

   always_comb begin
      w_err_next = r_csum_err;
      if (w_start) begin
         w_err_next = 1'b0;
      end else if (r_state == c_ST_CHECK) begin
         w_err_next = (csum != exp_csum);
      end
   end

   // Outputs are registered from the next state so they line up with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_ST_IDLE;
         r_row      <= '0;
         r_byte     <= '0;
         r_s_ready  <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_row   <= '0;
         r_wr_data  <= '0;
         r_pal_oe_n <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_csum_err <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_s_ready  <= (w_next == c_ST_LOAD);
         r_wr_en    <= (w_next == c_ST_WRITE);
         r_busy     <= (w_next == c_ST_LOAD) || (w_next == c_ST_WRITE) || (w_next == c_ST_CHECK);
         r_done     <= (w_next == c_ST_DONE);
         r_pal_oe_n <= !((w_next == c_ST_DONE) && !w_err_next);
         r_csum_err <= w_err_next;

         if (w_start) begin
            r_row  <= '0;
            r_byte <= '0;
         end
         if (w_accept) begin
            r_wr_data[{r_byte, 3'b000} +: 8] <= bus.s_data;
            r_byte <= w_last_byte ? '0 : r_byte + 1'b1;
         end
         if ((r_state == c_ST_WRITE) && (w_next == c_ST_LOAD)) begin
            r_row <= r_row + 1'b1;
         end
         if (w_next == c_ST_WRITE) begin
            r_wr_row <= r_row;
         end
      end
   end

   galpal_csum16 u_csum (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_start),
      .i_add_en (w_accept),
      .i_data   (bus.s_data),
      .o_sum    (csum)
   );

   assign bus.s_ready = r_s_ready;
   assign bus.wr_en   = r_wr_en;
   assign bus.wr_row  = r_wr_row;
   assign bus.wr_data = r_wr_data;
   assign pal_oe_n    = r_pal_oe_n;
   assign busy        = r_busy;
   assign done        = r_done;
   assign csum_err    = r_csum_err;

endmodule
`default_nettype wire

// File: tb/tb_galpal_fuse_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_galpal_fuse_loader                                             |
// | Brief   : Directed self-checking bench for the PAL fuse loader.             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_galpal_fuse_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] exp_csum = 16'h0000;
   logic        pal_oe_n;
   logic        busy;
   logic        done;
   logic [15:0] csum;
   logic        csum_err;

   int n_chk  = 0;
   int n_pass = 0;

   galpal_fuse_loader_if #(.ROWS(64), .COLS(32)) bus ();

   galpal_fuse_loader #(.ROWS(64), .COLS(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .bus      (bus),
      .exp_csum (exp_csum),
      .pal_oe_n (pal_oe_n),
      .busy     (busy),
      .done     (done),
      .csum     (csum),
      .csum_err (csum_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Write/accept log, sampled mid-cycle
   int          wr_cnt   = 0;
   int          acc_cnt  = 0;
   int          done_cyc = -1;
   logic        done_q   = 1'b0;
   logic [5:0]  mon_row  [0:1023];
   logic [31:0] mon_data [0:1023];
   int          mon_cyc  [0:1023];
   int          acc_cyc  [0:2047];

   always @(negedge clk) begin
      if (bus.wr_en && wr_cnt < 1024) begin
         mon_row[wr_cnt]  = bus.wr_row;
         mon_data[wr_cnt] = bus.wr_data;
         mon_cyc[wr_cnt]  = cyc;
         wr_cnt++;
      end
      if (bus.s_valid && bus.s_ready && acc_cnt < 2048) begin
         acc_cyc[acc_cnt] = cyc;
         acc_cnt++;
      end
      if (done && !done_q) done_cyc = cyc;
      done_q = done;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bytes 0,1,2.. in order; junk mode shows 0x5A whenever the loader is not ready
   task automatic run_stream(input int nbytes, input bit gaps, input bit junk);
      int i      = 0;
      int budget = 5000;
      bit acc;
      while (i < nbytes && budget > 0) begin
         if (junk && !bus.s_ready) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'h5A;
         end else begin
            bus.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_data  = 8'(i);
         end
         acc = bus.s_valid && bus.s_ready;
         tick();
         if (acc) i++;
         budget--;
      end
      bus.s_valid = 1'b0;
      chk("stream_accepted", 64'(i), 64'(nbytes));
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 50) begin
         tick();
         n++;
      end
      chk(tag, {63'd0, done}, 64'd1);
   endtask

   function automatic int bad_rows(input int base);
      int          bad = 0;
      logic [31:0] e;
      for (int k = 0; k < 64; k++) begin
         e = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
         if (mon_row[base+k] !== 6'(k) || mon_data[base+k] !== e) bad++;
      end
      return bad;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_w;
      int base_a;
      bus.s_data  = 8'h00;
      bus.s_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_flags", {bus.s_ready, bus.wr_en, busy, done, csum_err, pal_oe_n}, 6'b000001);
      chk("reset_row_data_csum", {bus.wr_row, bus.wr_data, csum}, 0);

      // Asynchronous reset in the middle of row 1
      start = 1'b1; tick(); start = 1'b0;
      run_stream(6, 1'b0, 1'b0);
      chk("midload_busy_csum", {busy, csum}, {1'b1, 16'd15});
      #3 rst = 1'b1;
      #1;
      chk("midload_rst_flags", {bus.s_ready, bus.wr_en, busy, done, csum_err, pal_oe_n}, 6'b000001);
      chk("midload_rst_row_data_csum", {bus.wr_row, bus.wr_data, csum}, 0);
      tick(); rst = 1'b0; tick();

      // Full clean load, no gaps
      exp_csum = 16'h7F80;
      base_w = wr_cnt; base_a = acc_cnt;
      start = 1'b1; tick(); start = 1'b0;
      run_stream(256, 1'b0, 1'b0);
      wait_done("clean_done");
      tick();
      chk("clean_wr_count", 64'(wr_cnt - base_w), 64);
      chk("clean_row0_data", mon_data[base_w], 32'h03020100);
      chk("clean_row63", {mon_row[base_w+63], mon_data[base_w+63]}, {6'd63, 32'hFFFEFDFC});
      chk("clean_bad_rows", 64'(bad_rows(base_w)), 0);
      chk("clean_csum", csum, 16'h7F80);
      chk("clean_err_oe_busy", {csum_err, pal_oe_n, busy}, 3'b000);
      chk("clean_latency", 64'(mon_cyc[base_w+63] - acc_cyc[base_a]), 319);
      chk("clean_done_lag", 64'(done_cyc - mon_cyc[base_w+63]), 2);

      // Restart from DONE with a wrong expected checksum
      exp_csum = 16'h7F81;
      start = 1'b1; tick(); start = 1'b0;
      chk("restart_oe_done_busy_csum", {pal_oe_n, done, busy, csum}, {3'b101, 16'd0});
      run_stream(256, 1'b0, 1'b0);
      wait_done("bad_done");
      tick();
      chk("bad_done_err_oe", {done, csum_err, pal_oe_n}, 3'b111);
      chk("bad_csum", csum, 16'h7F80);

      // Random valid gaps
      exp_csum = 16'h7F80;
      base_w = wr_cnt;
      start = 1'b1; tick(); start = 1'b0;
      run_stream(256, 1'b1, 1'b0);
      wait_done("gaps_done");
      tick();
      chk("gaps_wr_count", 64'(wr_cnt - base_w), 64);
      chk("gaps_bad_rows", 64'(bad_rows(base_w)), 0);
      chk("gaps_csum_err_oe", {csum, csum_err, pal_oe_n}, {16'h7F80, 2'b00});

      // Abort during the row 10 write, then reload
      start = 1'b1; tick(); start = 1'b0;
      run_stream(44, 1'b0, 1'b0);
      chk("abort_pre_write", {bus.wr_en, bus.wr_row}, {1'b1, 6'd10});
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_flags", {bus.s_ready, bus.wr_en, busy, done, pal_oe_n}, 5'b00001);
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      chk("abort_beats_start", {busy, bus.s_ready}, 2'b00);
      base_w = wr_cnt;
      start = 1'b1; tick(); start = 1'b0;
      chk("reload_csum_cleared", csum, 0);
      run_stream(256, 1'b0, 1'b0);
      wait_done("reload_done");
      tick();
      chk("reload_first_row", mon_row[base_w], 0);
      chk("reload_wr_count", 64'(wr_cnt - base_w), 64);
      chk("reload_csum_oe", {csum, pal_oe_n}, {16'h7F80, 1'b0});

      // start held through the load, junk bytes offered while not ready
      base_w = wr_cnt;
      start = 1'b1; tick();
      run_stream(256, 1'b0, 1'b1);
      start = 1'b0;
      wait_done("hold_done");
      tick();
      chk("hold_wr_count", 64'(wr_cnt - base_w), 64);
      chk("hold_bad_rows", 64'(bad_rows(base_w)), 0);
      chk("hold_csum_oe", {csum, csum_err, pal_oe_n}, {16'h7F80, 2'b00});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
